// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: Y86-64 pipeline stall/bubble sequencer with halt latch and hazard counters
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       E_dstM_i,
  input  logic             e_Cnd_i,
  input  logic [3:0]       M_icode_i,
  input  logic [2:0]       m_stat_i,
  input  logic [2:0]       W_stat_i,
  input  logic             dmem_ready_i,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             D_bubble_o,
  output logic             E_stall_o,
  output logic             E_bubble_o,
  output logic             M_stall_o,
  output logic             M_bubble_o,
  output logic             W_stall_o,
  output logic             W_bubble_o,
  output logic             halted_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] loaduse_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o,
  output logic [CNT_W-1:0] ret_cnt_o,
  output logic [CNT_W-1:0] memwait_cnt_o
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALTED = 2'd2, ILLEGAL = 2'd3} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] lu_q, mp_q, rt_q, mw_q;
  logic loaduse, mispred, ret, memop, mexc, wexc;
  logic inc_lu, inc_mp, inc_rt, inc_mw;
  assign loaduse = (E_icode_i == 4'h5 || E_icode_i == 4'hB) && E_dstM_i != 4'hF &&
                   (E_dstM_i == d_srcA_i || E_dstM_i == d_srcB_i);
  assign mispred = E_icode_i == 4'h7 && !e_Cnd_i;
  assign ret     = D_icode_i == 4'h9 || E_icode_i == 4'h9 || M_icode_i == 4'h9;
  assign memop   = M_icode_i inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign mexc    = m_stat_i != 3'd1;
  assign wexc    = W_stat_i != 3'd1;
  assign halted_o      = state_q == HALTED;
  assign state_o       = state_q;
  assign loaduse_cnt_o = lu_q;
  assign mispred_cnt_o = mp_q;
  assign ret_cnt_o     = rt_q;
  assign memwait_cnt_o = mw_q;
  // Control outputs, next state and counter strobes; reset forces every register to load a NOP
  always_comb begin
    F_stall_o  = 1'b0;
    D_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_stall_o  = 1'b0;
    E_bubble_o = 1'b0;
    M_stall_o  = 1'b0;
    M_bubble_o = 1'b0;
    W_stall_o  = 1'b0;
    W_bubble_o = 1'b0;
    state_d    = RUN;
    inc_lu     = 1'b0;
    inc_mp     = 1'b0;
    inc_rt     = 1'b0;
    inc_mw     = 1'b0;
    if (!rst_n_i) begin
      D_bubble_o = 1'b1;
      E_bubble_o = 1'b1;
      M_bubble_o = 1'b1;
      W_bubble_o = 1'b1;
    end else if (state_q == HALTED) begin
      F_stall_o = 1'b1;
      D_stall_o = 1'b1;
      E_stall_o = 1'b1;
      M_stall_o = 1'b1;
      W_stall_o = 1'b1;
      state_d   = HALTED;
    end else if (state_q == RUN || state_q == MEM_WAIT) begin
      if (wexc) begin
        W_stall_o  = 1'b1;
        M_bubble_o = 1'b1;
        state_d    = HALTED;
      end else if (memop && !dmem_ready_i) begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_stall_o  = 1'b1;
        M_stall_o  = 1'b1;
        W_bubble_o = 1'b1;
        state_d    = MEM_WAIT;
        inc_mw     = 1'b1;
      end else begin
        F_stall_o  = loaduse | ret;
        D_stall_o  = loaduse;
        D_bubble_o = mispred | (ret & ~loaduse);
        E_bubble_o = mispred | loaduse;
        M_bubble_o = mexc;
        inc_lu     = loaduse;
        inc_mp     = mispred;
        inc_rt     = ret & ~loaduse & ~mispred;
      end
    end
  end
  // State register and saturating event counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      lu_q    <= '0;
      mp_q    <= '0;
      rt_q    <= '0;
      mw_q    <= '0;
    end else begin
      state_q <= state_d;
      if (inc_lu && ~&lu_q) lu_q <= lu_q + CNT_W'(1);
      if (inc_mp && ~&mp_q) mp_q <= mp_q + CNT_W'(1);
      if (inc_rt && ~&rt_q) rt_q <= rt_q + CNT_W'(1);
      if (inc_mw && ~&mw_q) mw_q <= mw_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of the hazard controller against a rule-level model
module tb_pipe_hazard_ctrl;
  localparam int W = 4;
  localparam int MAXC = (1 << W) - 1;
  localparam logic [11:0] RST_CTL  = 12'b001010101000;
  localparam logic [11:0] HALT_CTL = 12'b110101010110;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic e_Cnd, dmem_ready;
  logic [2:0] m_stat, W_stat;
  logic F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall, W_bubble, halted;
  logic [1:0] state;
  logic [W-1:0] lu_cnt, mp_cnt, rt_cnt, mw_cnt;
  logic [11:0] ctl, exp_ctl;
  logic [1:0] m_mode;
  int c_lu, c_mp, c_rt, c_mw;
  int total = 0, bad = 0;
  logic t_lu, t_mp, t_rt, t_mo;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
    .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd),
    .M_icode_i(M_icode), .m_stat_i(m_stat), .W_stat_i(W_stat), .dmem_ready_i(dmem_ready),
    .F_stall_o(F_stall), .D_stall_o(D_stall), .D_bubble_o(D_bubble),
    .E_stall_o(E_stall), .E_bubble_o(E_bubble), .M_stall_o(M_stall), .M_bubble_o(M_bubble),
    .W_stall_o(W_stall), .W_bubble_o(W_bubble), .halted_o(halted), .state_o(state),
    .loaduse_cnt_o(lu_cnt), .mispred_cnt_o(mp_cnt), .ret_cnt_o(rt_cnt), .memwait_cnt_o(mw_cnt)
  );

  assign ctl = {F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall, W_bubble, halted, state};

  assign t_lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF && (E_dstM == d_srcA || E_dstM == d_srcB);
  assign t_mp = E_icode == 4'h7 && !e_Cnd;
  assign t_rt = D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
  assign t_mo = M_icode == 4'h4 || M_icode == 4'h5 || M_icode == 4'h8 || M_icode == 4'h9 || M_icode == 4'hA || M_icode == 4'hB;

  // Expected control word from the rule table, mode 0/1/2 = run/wait/halted
  always_comb begin
    exp_ctl = '0;
    if (!rst_n) exp_ctl = RST_CTL;
    else if (m_mode == 2'd2) exp_ctl = HALT_CTL;
    else if (W_stat != 3'd1) exp_ctl = {9'b000000110, 1'b0, m_mode};
    else if (t_mo && !dmem_ready) exp_ctl = {9'b110101001, 1'b0, m_mode};
    else exp_ctl = {t_lu | t_rt, t_lu, t_mp | (t_rt & ~t_lu), 1'b0, t_mp | t_lu, 1'b0, m_stat != 3'd1, 2'b00, 1'b0, m_mode};
  end

  function automatic int sat(input int v);
    return v >= MAXC ? MAXC : v + 1;
  endfunction

  // Model mode and event counts advance on each clock edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 2'd0;
      c_lu <= 0; c_mp <= 0; c_rt <= 0; c_mw <= 0;
    end else if (m_mode != 2'd2) begin
      if (W_stat != 3'd1) m_mode <= 2'd2;
      else if (t_mo && !dmem_ready) begin
        m_mode <= 2'd1;
        c_mw <= sat(c_mw);
      end else begin
        m_mode <= 2'd0;
        if (t_lu) c_lu <= sat(c_lu);
        if (t_mp) c_mp <= sat(c_mp);
        if (t_rt && !t_lu && !t_mp) c_rt <= sat(c_rt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("ctl", 32'(ctl), 32'(exp_ctl));
    chk("loaduse_cnt", 32'(lu_cnt), c_lu);
    chk("mispred_cnt", 32'(mp_cnt), c_mp);
    chk("ret_cnt", 32'(rt_cnt), c_rt);
    chk("memwait_cnt", 32'(mw_cnt), c_mw);
  end

  task automatic idle;
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b1;
    M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1; dmem_ready = 1'b1;
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic set_loaduse;
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
  endtask

  initial begin
    idle();
    repeat (2) smp();
    chk("lit_reset_ctl", 32'(ctl), 32'(RST_CTL));
    nxt();
    rst_n = 1'b1;
    set_loaduse();
    smp();
    chk("lit_loaduse_ctl", 32'(ctl), 32'h0C80);
    nxt();
    idle();
    smp();
    chk("lit_loaduse_cnt", 32'(lu_cnt), 1);
    chk("lit_idle_ctl", 32'(ctl), 0);
    nxt();
    E_icode = 4'h7; e_Cnd = 1'b0;
    smp();
    chk("lit_mispred_ctl", 32'(ctl), 32'h0280);
    nxt();
    e_Cnd = 1'b1;
    smp();
    chk("lit_mispred_cnt", 32'(mp_cnt), 1);
    chk("lit_taken_ctl", 32'(ctl), 0);
    nxt();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 3) D_icode = 4'h9;
      else if (i == 3) E_icode = 4'h9;
      else M_icode = 4'h9;
      smp();
      chk("lit_ret_ctl", 32'(ctl), 32'h0A00);
      nxt();
    end
    idle();
    smp();
    chk("lit_ret_cnt", 32'(rt_cnt), 5);
    nxt();
    D_icode = 4'h9;
    set_loaduse();
    smp();
    chk("lit_ret_loaduse_ctl", 32'(ctl), 32'h0C80);
    nxt();
    idle();
    smp();
    chk("lit_ret_loaduse_lu", 32'(lu_cnt), 2);
    chk("lit_ret_loaduse_rt", 32'(rt_cnt), 5);
    nxt();
    M_icode = 4'h5; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("lit_memwait_ctl", 32'(ctl), i == 0 ? 32'h0D48 : 32'h0D49);
      nxt();
    end
    dmem_ready = 1'b1;
    smp();
    chk("lit_memready_ctl", 32'(ctl), 32'h0001);
    nxt();
    idle();
    smp();
    chk("lit_memwait_cnt", 32'(mw_cnt), 4);
    chk("lit_back_to_run", 32'(state), 0);
    nxt();
    for (int i = 0; i < 30; i++) begin
      D_icode = 4'($urandom_range(0, 11)); d_srcA = 4'($urandom_range(0, 15)); d_srcB = 4'($urandom_range(0, 15));
      E_icode = 4'($urandom_range(0, 11)); E_dstM = 4'($urandom_range(0, 15)); e_Cnd = 1'($urandom_range(0, 1));
      M_icode = 4'($urandom_range(0, 11)); m_stat = 3'($urandom_range(0, 7)); dmem_ready = 1'($urandom_range(0, 1));
      W_stat = 3'd1;
      nxt();
    end
    idle();
    nxt();
    M_icode = 4'h5; dmem_ready = 1'b0;
    nxt();
    nxt();
    W_stat = 3'd3;
    smp();
    chk("lit_wexc_ctl", 32'(ctl), 32'h0031);
    nxt();
    for (int i = 0; i < 10; i++) begin
      D_icode = 4'($urandom_range(0, 15)); E_icode = 4'($urandom_range(0, 15)); M_icode = 4'($urandom_range(0, 15));
      E_dstM = 4'($urandom_range(0, 15)); d_srcA = 4'($urandom_range(0, 15)); e_Cnd = 1'($urandom_range(0, 1));
      W_stat = 3'($urandom_range(0, 7)); m_stat = 3'($urandom_range(0, 7)); dmem_ready = 1'($urandom_range(0, 1));
      smp();
      chk("lit_halted_ctl", 32'(ctl), 32'(HALT_CTL));
      nxt();
    end
    #2 rst_n = 1'b0;
    #1 chk("lit_halt_reset_ctl", 32'(ctl), 32'(RST_CTL));
    nxt();
    idle();
    rst_n = 1'b1;
    M_icode = 4'h5; dmem_ready = 1'b0;
    nxt();
    nxt();
    smp();
    chk("lit_wait_before_reset", 32'(ctl), 32'h0D49);
    #2 rst_n = 1'b0;
    #1 chk("lit_wait_reset_ctl", 32'(ctl), 32'(RST_CTL));
    chk("lit_wait_reset_cnt", 32'(mw_cnt), 0);
    nxt();
    idle();
    rst_n = 1'b1;
    set_loaduse();
    repeat (20) nxt();
    idle();
    smp();
    chk("lit_loaduse_sat", 32'(lu_cnt), 15);
    nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
